// File: rtl/gf32_div_xk.sv
// Iterative divide-by-x^k in GF(2^32), p(x) = x^32 + x^7 + x^3 + x^2 + 1.
// Each RUN cycle applies one multiply-by-x^-1 step. This undoes one step of
// the combinational doubling stage. The result is held until the consumer
// accepts it.
module gf32_div_xk #(
    parameter int unsigned K_W      = 5,
    parameter logic [31:0] POLY_LOW = 32'h0000_008D
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_data,
    input  logic [K_W-1:0] in_k,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [31:0]    acc_q, acc_d;
    logic [K_W-1:0] cnt_q, cnt_d;
    logic [31:0]    step_res;
    logic           accept;

    // One multiply-by-x^-1 step. If b[0] is set, adding p(x) makes the value
    // divisible by x. The x^32 term of p(x) then shifts down into bit 31.
    function automatic logic [31:0] div_x(input logic [31:0] b);
        logic [31:0] r;
        r     = (b ^ (b[0] ? POLY_LOW : 32'h0)) >> 1;
        r[31] = b[0];
        return r;
    endfunction

    assign step_res = div_x(acc_q);
    assign accept   = in_valid & in_ready;
    assign out_data = acc_q;

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (in_k == '0) ? StDone : StRun;
                end
            end
            StRun: begin
                if (cnt_q == K_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            StIdle:  in_ready  = 1'b1;
            StRun:   ;
            StDone:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: capture on accept, step and count down in RUN
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    acc_d = in_data;
                    cnt_d = in_k;
                end
            end
            StRun: begin
                acc_d = step_res;
                cnt_d = cnt_q - K_W'(1);
            end
            StDone:  ;
            default: ;
        endcase
    end

    // Datapath registers; reset clears them and drops any in-flight operation
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= 32'h0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: tb/tb_gf32_div_xk.sv
// Directed and randomized bench for gf32_div_xk. The expected results come
// from an independent multiply-by-x reference model.
module tb_gf32_div_xk;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = 32'h0;
    logic [4:0]  in_k = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    gf32_div_xk dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_k     (in_k),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    // Reference doubling: a*x mod p
    function automatic logic [31:0] mulx(input logic [31:0] a);
        logic [31:0] r;
        r = a << 1;
        if (a[31]) r = r ^ 32'h0000_008D;
        return r;
    endfunction

    function automatic logic [31:0] mulx_k(input logic [31:0] a, input int k);
        logic [31:0] r;
        r = a;
        for (int i = 0; i < k; i++) r = mulx(r);
        return r;
    endfunction

    // Present a request and hold it until accepted (bounded); returns with
    // in_valid low, #1 after the accept edge.
    task automatic issue(input logic [31:0] d, input int k, output bit ok);
        int g;
        in_data  = d;
        in_k     = 5'(k);
        in_valid = 1'b1;
        g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count cycles until out_valid rises (capped at 100)
    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b out_data=%h, want 1 0 00000000",
                     in_ready, out_valid, out_data);
        end
    endtask

    task automatic test_basic();
        bit ok;
        int lat;
        logic [31:0] vin [3];
        logic [31:0] vexp[3];
        int          vk  [3];
        vin[0] = 32'h0000_0001; vk[0] = 1; vexp[0] = 32'h8000_0046;
        vin[1] = 32'h0000_0002; vk[1] = 1; vexp[1] = 32'h0000_0001;
        vin[2] = 32'h1234_5678; vk[2] = 0; vexp[2] = 32'h1234_5678;
        for (int i = 0; i < 3; i++) begin
            issue(vin[i], vk[i], ok);
            checks++;
            if (!ok || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL basic_accept[%0d]: accepted=%b in_ready=%b, want 1 0",
                         i, ok, in_ready);
            end
            wait_out(lat);
            checks++;
            if (lat != vk[i]) begin
                errors++;
                $display("FAIL basic_latency[%0d]: got %0d want %0d", i, lat, vk[i]);
            end
            checks++;
            if (out_data !== vexp[i] || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL basic_data[%0d]: got %h in_ready=%b want %h in_ready=0",
                         i, out_data, in_ready, vexp[i]);
            end
            drain();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL basic_release[%0d]: out_valid=%b in_ready=%b want 0 1",
                         i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        int lat;
        int k;
        logic [31:0] a;
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            k = $urandom_range(0, 31);
            issue(mulx_k(a, k), k, ok);
            wait_out(lat);
            checks++;
            if (!ok || lat != k || out_data !== a) begin
                errors++;
                $display("FAIL random[%0d]: k=%0d lat=%0d got %h want lat %0d data %h",
                         i, k, lat, out_data, k, a);
            end
            drain();
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [31:0] a;
        a = 32'hDEAD_BEEF;
        issue(mulx_k(a, 31), 31, ok);
        lat = 0;
        // Pulse stray requests while running; none may be taken
        while (!out_valid && lat < 100) begin
            in_valid = lat[0];
            in_data  = 32'h0000_0001;
            in_k     = 5'd0;
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_run_ready: cycle %0d in_ready=%b want 0", lat, in_ready);
            end
            @(posedge clk); #1; lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (!ok || lat != 31 || out_data !== a) begin
            errors++;
            $display("FAIL bp_result: lat=%0d got %h want lat 31 data %h", lat, out_data, a);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = ~in_valid;
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || out_data !== a || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b data=%h in_ready=%b want 1 %h 0",
                         c, out_valid, out_data, in_ready, a);
            end
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        issue(32'h0000_0001, 1, ok);
        wait_out(lat);
        checks++;
        if (!ok || lat != 1 || out_data !== 32'h8000_0046) begin
            errors++;
            $display("FAIL bp_next: lat=%0d got %h want lat 1 data 80000046", lat, out_data);
        end
        drain();
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        issue(mulx_k(32'hCAFE_F00D, 20), 20, ok);
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset: in_ready=%b out_valid=%b data=%h want 1 0 00000000",
                     in_ready, out_valid, out_data);
        end
        issue(32'h0000_0001, 1, ok);
        wait_out(lat);
        checks++;
        if (!ok || lat != 1 || out_data !== 32'h8000_0046) begin
            errors++;
            $display("FAIL midrun_after: lat=%0d got %h want lat 1 data 80000046", lat, out_data);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        localparam int N = 6;
        logic [31:0] ea[N];
        int          ek[N];
        int          acc_cyc[N];
        int          got;
        ea[0] = 32'h0000_0001; ek[0] = 0;
        ea[1] = 32'h8000_0000; ek[1] = 1;
        ea[2] = 32'h1357_9BDF; ek[2] = 3;
        ea[3] = 32'hFFFF_FFFF; ek[3] = 0;
        ea[4] = 32'h0F0F_0F0F; ek[4] = 7;
        ea[5] = 32'hA5A5_5A5A; ek[5] = 2;
        got = 0;
        out_ready = 1'b1;
        fork
            begin
                int g;
                for (int i = 0; i < N; i++) begin
                    in_data  = mulx_k(ea[i], ek[i]);
                    in_k     = 5'(ek[i]);
                    in_valid = 1'b1;
                    g = 0;
                    while (!in_ready && g < 200) begin
                        @(posedge clk); #1; g++;
                    end
                    @(posedge clk); #1;
                    acc_cyc[i] = cyc;
                end
                in_valid = 1'b0;
            end
            begin
                int g;
                g = 0;
                while (got < N && g < 500) begin
                    @(posedge clk); #1; g++;
                    if (out_valid) begin
                        checks++;
                        if (out_data !== ea[got]) begin
                            errors++;
                            $display("FAIL b2b_data[%0d]: got %h want %h",
                                     got, out_data, ea[got]);
                        end
                        got++;
                    end
                end
            end
        join
        checks++;
        if (got != N) begin
            errors++;
            $display("FAIL b2b_count: got %0d results want %0d", got, N);
        end
        for (int i = 1; i < N; i++) begin
            checks++;
            if (acc_cyc[i] - acc_cyc[i-1] != ek[i-1] + 2) begin
                errors++;
                $display("FAIL b2b_spacing[%0d]: got %0d cycles want %0d",
                         i, acc_cyc[i] - acc_cyc[i-1], ek[i-1] + 2);
            end
        end
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL b2b_extra[%0d]: out_valid=%b want 0", c, out_valid);
            end
        end
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gf32_div_xk.md
Name: gf32_div_xk

Overview:
- Iterative divider by x^k in GF(2^32), field polynomial p(x) = x^32 + x^7 + x^3 + x^2 + 1.
- Inverse direction of the team's combinational multiply-by-x (doubling) stage.
- Accepts a 32-bit field element and shift count k, performs one multiply-by-x^-1 step per clock, and returns a·x^-k over a valid/ready handshake.
- Used in unmasking/undoing chains of doubling operations in the white-box datapath.

Parameters:
- K_W, 5, width of shift count; k ranges 0..2^K_W-1.
- POLY_LOW, 32'h0000_008D, low 32 bits of p(x) (bits 0,2,3,7); reduction constant.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  request valid
- in_ready  output  1  block can accept request
- in_data  input  32  field element b
- in_k  input  K_W  number of divide-by-x steps
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_data  output  32  result b·x^-k mod p

Behaviour:
- Single step, combinational helper inside block: d = (b ^ (b[0] ? POLY_LOW : 0)) >> 1, then d[31] = b[0].
  - Exact inverse of multiply-by-x: for any a, step(a·x mod p) = a.
- Reset, sampled on clk when rst_n=0, regardless of state including mid-RUN:
  - state=IDLE, in_ready=1, out_valid=0, out_data=0, step counter=0.
  - Any in-flight operation is discarded.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: latch in_data into acc, in_k into cnt.
  - If in_k==0, go to DONE (out_data=in_data). Else go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each clk: acc <= step(acc), cnt <= cnt-1.
  - When cnt==1 at the edge, go to DONE.
- DONE:
  - out_valid=1, out_data=acc, in_ready=0.
  - Hold out_data and out_valid stable while out_ready=0; indefinite backpressure is legal.
  - On out_ready=1: go to IDLE, out_valid=0 next cycle.
- Latency:
  - Accept edge at cycle T.
  - out_valid first high after edge T+k for k≥1.
  - out_valid first high after edge T for k=0.
  - Throughput: one request per k+2 cycles minimum (IDLE re-entry cycle included).
- in_valid while in_ready=0: ignored; the request is not captured. Upstream must hold it until in_ready.
- in_data/in_k changes after acceptance have no effect.
- Counter arithmetic unsigned K_W bits. No wrap: cnt never decremented below 1 in RUN.
- Maximum k = 2^K_W-1 (31 by default); x^-31 handled with no special case.
- out_data is registered; there is no combinational path from in_* to out_*.

Test Plan:
- Reset then in_data=32'h0000_0001, k=1 -> out_data=32'h8000_0046, out_valid high exactly 1 cycle after accept edge; in_ready low until out handshake.
- in_data=32'h0000_0002, k=1 -> 32'h0000_0001; in_data=32'h1234_5678, k=0 -> 32'h1234_5678 on the cycle after accept.
- Random a, k in 0..31: feed reference multiply-by-x applied k times to a -> out_data==a; latency==k cycles (k≥1), 1000 vectors.
- k=31, out_ready held low 10 cycles after out_valid -> out_data/out_valid stable; in_valid pulses during RUN/DONE not captured; release -> IDLE, next request accepted.
- rst_n=0 for one cycle mid-RUN (k=20, after 5 steps) -> next cycle state IDLE, in_ready=1, out_valid=0, out_data=0; subsequent k=1 request on 32'h0000_0001 returns 32'h8000_0046.
- Back-to-back: in_valid held high with out_ready=1 -> accepts every k+2 cycles, results in order, no duplicated or dropped transactions.
